csr_access_unit: RTL and testbench

Initiator side of the CSR file port: accepts one decoded Zicsr instruction at a time from the execute stage and performs the read-modify-write sequence against the CSR file. It drives `csr_addr` / `csr_wdata` / `csr_wen` and samples `csr_rdata`. It then returns the old CSR value, or an illegal-instruction flag, to writeback through a valid/ready response. It sits between execute and the CSR file, so the CSR file never sees more than one write per instruction.

---
 rtl/csr_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_csr_access_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit
// Initiator side of the CSR file port. Takes one decoded Zicsr instruction
// from execute and runs a READ -> WRITE sequence against the CSR file. It
// returns the old CSR value, or an illegal-instruction flag, to writeback.
//
// Optional feature macro: CSR_ACCESS_PRIV_CHECK_EN
//   When defined, two more requests are illegal: a CSR whose privilege field
//   is above req_priv, and a write to read-only CSR space. When undefined,
//   req_priv is unused.
//
// Ports:
//   ctrl_clk, ctrl_reset_n   clock (rising edge), async active-low reset
//   req_*                    request from execute (valid/ready)
//   csr_addr/wdata/wen       registered command to the CSR file
//   csr_rdata                combinational read data from the CSR file
//   rsp_*                    response to writeback (valid/ready)
module csr_access_unit (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_rs1_idx,
  input  logic [4:0]  req_rd_idx,
  input  logic [1:0]  req_priv,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_wen,
  input  logic [31:0] csr_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd_idx,
  output logic        rsp_illegal
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
  logic [REG_AW-1:0] rs1_idx_q, rs1_idx_d;

  logic              req_ready_d;
  logic [CSR_AW-1:0] csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_d;
  logic              csr_wen_d;
  logic              rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_d;
  logic [REG_AW-1:0] rsp_rd_idx_d;
  logic              rsp_illegal_d;

  // Implemented CSR set
  logic implemented;
  always_comb begin
    implemented = 1'b0;
    case (req_csr)
      12'h300, 12'h301, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344: implemented = 1'b1;
      default: implemented = 1'b0;
    endcase
  end

  // Privilege / read-only checks on the incoming request
  logic priv_ok;
`ifdef CSR_ACCESS_PRIV_CHECK_EN
  logic req_do_write;
  assign req_do_write = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != REG_AW'(0));
  assign priv_ok = (req_csr[9:8] <= req_priv) &&
                   !((req_csr[11:10] == 2'b11) && req_do_write);
`else
  logic unused_priv;
  assign unused_priv = ^req_priv;
  assign priv_ok     = 1'b1;
`endif

  logic req_legal;
  assign req_legal = implemented && (req_funct3[1:0] != 2'b00) && priv_ok;

  // Read-modify-write datapath on the latched instruction
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_val;
  logic            do_write;
  assign src      = funct3_q[2] ? XLEN'(rs1_idx_q) : rs1_val_q;
  assign do_write = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != REG_AW'(0));

  always_comb begin
    new_val = src;
    case (funct3_q[1:0])
      2'b10:   new_val = csr_rdata | src;
      2'b11:   new_val = csr_rdata & ~src;
      default: new_val = src;
    endcase
  end

  // Next-state and next-output logic; outputs are registered so csr_wen is
  // set up while in READ and is high exactly during the WRITE cycle.
  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    rs1_val_d     = rs1_val_q;
    rs1_idx_d     = rs1_idx_q;
    req_ready_d   = req_ready;
    csr_addr_d    = csr_addr;
    csr_wdata_d   = csr_wdata;
    csr_wen_d     = 1'b0;
    rsp_valid_d   = rsp_valid;
    rsp_data_d    = rsp_data;
    rsp_rd_idx_d  = rsp_rd_idx;
    rsp_illegal_d = rsp_illegal;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          csr_addr_d   = req_csr;
          funct3_d     = req_funct3;
          rs1_val_d    = req_rs1_val;
          rs1_idx_d    = req_rs1_idx;
          rsp_rd_idx_d = req_rd_idx;
          rsp_data_d   = '0;
          req_ready_d  = 1'b0;
          if (req_legal) begin
            rsp_illegal_d = 1'b0;
            state_d       = ST_READ;
          end else begin
            rsp_illegal_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
          end
        end
      end
      ST_READ: begin
        rsp_data_d = csr_rdata;
        if (do_write) begin
          csr_wen_d   = 1'b1;
          csr_wdata_d = new_val;
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      rs1_val_q   <= '0;
      rs1_idx_q   <= '0;
      req_ready   <= 1'b1;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      csr_wen     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_rd_idx  <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      rs1_val_q   <= rs1_val_d;
      rs1_idx_q   <= rs1_idx_d;
      req_ready   <= req_ready_d;
      csr_addr    <= csr_addr_d;
      csr_wdata   <= csr_wdata_d;
      csr_wen     <= csr_wen_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_rd_idx  <= rsp_rd_idx_d;
      rsp_illegal <= rsp_illegal_d;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR file model.
module tb_csr_access_unit;

  logic        ctrl_clk;
  logic        ctrl_reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  logic [1:0]  req_priv;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd_idx;
  logic        rsp_illegal;

  int checks   = 0;
  int failures = 0;

  csr_access_unit dut (
    .ctrl_clk     (ctrl_clk),
    .ctrl_reset_n (ctrl_reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr      (req_csr),
    .req_rs1_val  (req_rs1_val),
    .req_rs1_idx  (req_rs1_idx),
    .req_rd_idx   (req_rd_idx),
    .req_priv     (req_priv),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_wen      (csr_wen),
    .csr_rdata    (csr_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_rd_idx   (rsp_rd_idx),
    .rsp_illegal  (rsp_illegal)
  );

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  // CSR file model: combinational read, write sampled at the rising edge
  logic [31:0] mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  assign csr_rdata = mem[csr_addr];

  always @(posedge ctrl_clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (csr_wen) mem[csr_addr] <= csr_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge ctrl_clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge ctrl_clk);
    #1 pre_en = 1'b0;
  endtask

  // Issue one request with rsp_ready high and check the full response timeline
  task automatic do_req(input string tag, input logic [2:0] f3, input logic [11:0] csr,
                        input logic [31:0] rs1v, input logic [4:0] rs1i, input logic [4:0] rd,
                        input logic [1:0] priv, input logic exp_ill, input logic exp_wen,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    int          lat;
    int          wen_cnt;
    logic [31:0] wd;
    lat     = exp_ill ? 1 : 3;
    wen_cnt = 0;
    wd      = '0;
    @(negedge ctrl_clk);
    req_funct3 = f3; req_csr = csr; req_rs1_val = rs1v; req_rs1_idx = rs1i;
    req_rd_idx = rd; req_priv = priv; req_valid = 1'b1; rsp_ready = 1'b1;
    check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge ctrl_clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge ctrl_clk);
      if (c == 1) begin
        req_valid = 1'b0;
        check({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
      end
      if (csr_wen) begin
        wen_cnt++;
        wd = csr_wdata;
      end
      if (c < lat) check({tag, ".rsp_valid_early"}, 32'(rsp_valid), 32'd0);
    end
    check({tag, ".rsp_valid"},   32'(rsp_valid),   32'd1);
    check({tag, ".rsp_illegal"}, 32'(rsp_illegal), 32'(exp_ill));
    check({tag, ".rsp_data"},    rsp_data,         exp_data);
    check({tag, ".rsp_rd_idx"},  32'(rsp_rd_idx),  32'(rd));
    check({tag, ".csr_wen_count"}, 32'(wen_cnt),   32'(exp_wen));
    check({tag, ".csr_wdata"},   wd,               exp_wen ? exp_wdata : 32'd0);
    @(negedge ctrl_clk);
    check({tag, ".rsp_valid_done"}, 32'(rsp_valid), 32'd0);
    check({tag, ".req_ready_done"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    req_valid = 1'b0; req_funct3 = '0; req_csr = '0; req_rs1_val = '0;
    req_rs1_idx = '0; req_rd_idx = '0; req_priv = 2'd3; rsp_ready = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset values
    repeat (3) @(negedge ctrl_clk);
    check("rst.req_ready",   32'(req_ready),   32'd1);
    check("rst.rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst.csr_wen",     32'(csr_wen),     32'd0);
    check("rst.csr_addr",    32'(csr_addr),    32'd0);
    check("rst.csr_wdata",   csr_wdata,        32'd0);
    check("rst.rsp_data",    rsp_data,         32'd0);
    check("rst.rsp_rd_idx",  32'(rsp_rd_idx),  32'd0);
    check("rst.rsp_illegal", 32'(rsp_illegal), 32'd0);
    ctrl_reset_n = 1'b1;

    preload(12'h340, 32'h1234_5678);
    preload(12'h304, 32'h0000_0888);
    preload(12'h300, 32'h0000_000A);
    preload(12'h341, 32'h0000_000F);
    preload(12'h342, 32'h0000_0055);
    preload(12'h343, 32'h0000_0011);
    preload(12'h344, 32'h0000_0042);

    // CSRRW mscratch
    do_req("csrrw_340", 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5, 5'd10, 2'd3,
           1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
    check("csrrw_340.mem", mem[12'h340], 32'hDEAD_BEEF);

    // CSRRS with rs1=x0: read only
    do_req("csrrs_304_x0", 3'b010, 12'h304, 32'hFFFF_FFFF, 5'd0, 5'd11, 2'd3,
           1'b0, 1'b0, 32'd0, 32'h0000_0888);
    check("csrrs_304_x0.mem", mem[12'h304], 32'h0000_0888);

    // CSRRCI mstatus, zimm=8: 0xA & ~8 = 0x2
    do_req("csrrci_300", 3'b111, 12'h300, 32'hFFFF_FFFF, 5'd8, 5'd12, 2'd3,
           1'b0, 1'b1, 32'h0000_0002, 32'h0000_000A);

    // CSRRS mepc: 0x0F | 0xF0 = 0xFF
    do_req("csrrs_341", 3'b010, 12'h341, 32'h0000_00F0, 5'd3, 5'd13, 2'd3,
           1'b0, 1'b1, 32'h0000_00FF, 32'h0000_000F);

    // CSRRSI with zimm=0: read only
    do_req("csrrsi_344_z0", 3'b110, 12'h344, 32'hFFFF_FFFF, 5'd0, 5'd14, 2'd3,
           1'b0, 1'b0, 32'd0, 32'h0000_0042);

    // Unimplemented address and reserved funct3
    do_req("ill_105", 3'b001, 12'h105, 32'h1111_1111, 5'd1, 5'd15, 2'd3,
           1'b1, 1'b0, 32'd0, 32'd0);
    do_req("ill_f3_100", 3'b100, 12'h340, 32'h2222_2222, 5'd1, 5'd16, 2'd3,
           1'b1, 1'b0, 32'd0, 32'd0);
    check("ill.mem_340", mem[12'h340], 32'hDEAD_BEEF);

    // User-mode CSRRS to mstatus (mstatus is 0x2 here)
`ifdef CSR_ACCESS_PRIV_CHECK_EN
    do_req("priv_u_300", 3'b010, 12'h300, 32'h0000_0001, 5'd1, 5'd17, 2'd0,
           1'b1, 1'b0, 32'd0, 32'd0);
    check("priv_u_300.mem", mem[12'h300], 32'h0000_0002);
`else
    do_req("priv_u_300", 3'b010, 12'h300, 32'h0000_0001, 5'd1, 5'd17, 2'd0,
           1'b0, 1'b1, 32'h0000_0003, 32'h0000_0002);
    check("priv_u_300.mem", mem[12'h300], 32'h0000_0003);
`endif

    // Backpressure: hold rsp_ready low, stray req_valid must be ignored
    @(negedge ctrl_clk);
    req_funct3 = 3'b001; req_csr = 12'h342; req_rs1_val = 32'h0000_0077;
    req_rs1_idx = 5'd4; req_rd_idx = 5'd7; req_priv = 2'd3;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge ctrl_clk);
    @(negedge ctrl_clk);
    req_valid = 1'b0;
    repeat (2) @(negedge ctrl_clk);
    check("hold.rsp_valid_first", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ctrl_clk);
      check("hold.rsp_valid",   32'(rsp_valid),   32'd1);
      check("hold.rsp_data",    rsp_data,         32'h0000_0055);
      check("hold.rsp_rd_idx",  32'(rsp_rd_idx),  32'd7);
      check("hold.req_ready",   32'(req_ready),   32'd0);
      check("hold.csr_wen",     32'(csr_wen),     32'd0);
      if (i == 1) begin
        req_valid = 1'b1; req_csr = 12'h300; req_rd_idx = 5'd9;
      end
      if (i == 3) req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge ctrl_clk);
    check("hold.rsp_valid_done", 32'(rsp_valid), 32'd0);
    check("hold.req_ready_done", 32'(req_ready), 32'd1);
    check("hold.mem_342",        mem[12'h342],    32'h0000_0077);
    check("hold.mem_300",        mem[12'h300],    mem[12'h300] & 32'h0000_0003);

    // Reset asserted during the WRITE cycle
    @(negedge ctrl_clk);
    req_funct3 = 3'b001; req_csr = 12'h343; req_rs1_val = 32'h0000_0099;
    req_rs1_idx = 5'd2; req_rd_idx = 5'd3; req_valid = 1'b1;
    @(posedge ctrl_clk);
    @(negedge ctrl_clk);
    req_valid = 1'b0;
    @(negedge ctrl_clk);
    check("rstw.csr_wen_before", 32'(csr_wen), 32'd1);
    #2 ctrl_reset_n = 1'b0;
    #1;
    check("rstw.csr_wen",   32'(csr_wen),   32'd0);
    check("rstw.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw.req_ready", 32'(req_ready), 32'd1);
    check("rstw.csr_addr",  32'(csr_addr),  32'd0);
    @(negedge ctrl_clk);
    ctrl_reset_n = 1'b1;
    @(negedge ctrl_clk);
    check("rstw.req_ready_after", 32'(req_ready), 32'd1);
    check("rstw.rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("rstw.mem_343",         mem[12'h343],    32'h0000_0011);

    // Normal operation after the interrupted instruction
    do_req("post_rst_343", 3'b101, 12'h343, 32'd0, 5'd21, 5'd4, 2'd3,
           1'b0, 1'b1, 32'h0000_0015, 32'h0000_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
